// File: rtl/gb_instr_issuer.sv
// gb_instr_issuer: buffers (instruction, operand) pairs pushed by a host and
// issues them to the gbprocessor ALU one at a time. It samples the processor
// probe a fixed LAT cycles after each issue and hands the value back through
// a result handshake.
// Optional feature: define GB_ISSUER_CNT_EN to add the 16-bit issued_cnt
// port and its counter.
module gb_instr_issuer #(
  parameter int INSTR_W = 8,
  parameter int DATA_W  = 8,
  parameter int PROBE_W = 8,
  parameter int DEPTH   = 8,
  parameter int LAT     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_valid,
  input  logic [INSTR_W-1:0]         push_instr,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  output logic [INSTR_W-1:0]         instruction,
  output logic [DATA_W-1:0]          data_out,
  output logic                       valid,
  input  logic [PROBE_W-1:0]         probe,
  output logic                       res_valid,
  output logic [PROBE_W-1:0]         res_data,
  input  logic                       res_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef GB_ISSUER_CNT_EN
  ,
  output logic [15:0]                issued_cnt
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [DATA_W-1:0]  fifo_data  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WAIT_W-1:0]  wait_cnt;

  logic fifo_empty;
  logic wr_en;
  logic pop_en;

  // push_ready follows the registered occupancy, so a pop only frees a slot
  // for the host in the following cycle.
  assign fifo_empty = (level == '0);
  assign push_ready = (level != LVL_W'(DEPTH));
  assign wr_en      = push_valid && push_ready;

  // valid and res_valid are pure decodes of the state register, so an
  // asynchronous reset clears them immediately.
  assign valid     = (state == ISSUE);
  assign res_valid = (state == HOLD);

  // Next-state decode; the FIFO pops on every transition into ISSUE.
  always_comb begin
    next_state = state;
    pop_en     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = ISSUE;
          pop_en     = 1'b1;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            next_state = ISSUE;
            pop_en     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Wait counter: loaded during ISSUE so WAIT spans exactly LAT cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= WAIT_W'(LAT - 1);
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  // Capture the processor probe on the last WAIT cycle; held through HOLD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_data <= '0;
    end else if ((state == WAIT) && (wait_cnt == '0)) begin
      res_data <= probe;
    end
  end

  // Operation registers take the FIFO head on pop and hold it afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction <= '0;
      data_out    <= '0;
    end else if (pop_en) begin
      instruction <= fifo_instr[rd_ptr];
      data_out    <= fifo_data[rd_ptr];
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      fifo_instr[wr_ptr] <= push_instr;
      fifo_data[wr_ptr]  <= push_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^PTR_W.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef GB_ISSUER_CNT_EN
  logic [15:0] issued_cnt_q;

  // Count one per ISSUE cycle; wraps from 0xFFFF to 0x0000.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issued_cnt_q <= '0;
    end else if (state == ISSUE) begin
      issued_cnt_q <= issued_cnt_q + 16'd1;
    end
  end

  assign issued_cnt = issued_cnt_q;
`endif

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Testbench for gb_instr_issuer: one LAT=1 instance compared every cycle
// against a queue-based timeline model, plus a LAT=4 instance used for the
// mid-operation reset scenario. Directed literal checks pin the model.
module tb_gb_instr_issuer;

  localparam int LAT1  = 1;
  localparam int LAT4  = 4;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       push_valid = 1'b0;
  logic [7:0] push_instr = 8'h00;
  logic [7:0] push_data  = 8'h00;
  logic       res_ready  = 1'b1;
  logic       push_ready;
  logic [7:0] instruction;
  logic [7:0] data_out;
  logic       valid;
  logic [7:0] probe;
  logic       res_valid;
  logic [7:0] res_data;
  logic [3:0] level;
  logic [15:0] issued_cnt;

  logic       p4v = 1'b0;
  logic [7:0] p4i = 8'h00;
  logic [7:0] p4d = 8'h00;
  logic       rr4 = 1'b1;
  logic       push_ready4;
  logic [7:0] instruction4;
  logic [7:0] data_out4;
  logic       valid4;
  logic [7:0] probe4;
  logic       res_valid4;
  logic [7:0] res_data4;
  logic [3:0] level4;
  logic [15:0] issued_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  gb_instr_issuer #(.INSTR_W(8), .DATA_W(8), .PROBE_W(8), .DEPTH(DEPTH), .LAT(LAT1)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_instr(push_instr), .push_data(push_data),
    .push_ready(push_ready), .instruction(instruction), .data_out(data_out),
    .valid(valid), .probe(probe), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .level(level)
`ifdef GB_ISSUER_CNT_EN
    , .issued_cnt(issued_cnt)
`endif
  );

  gb_instr_issuer #(.INSTR_W(8), .DATA_W(8), .PROBE_W(8), .DEPTH(DEPTH), .LAT(LAT4)) dut4 (
    .clock(clock), .reset(reset),
    .push_valid(p4v), .push_instr(p4i), .push_data(p4d),
    .push_ready(push_ready4), .instruction(instruction4), .data_out(data_out4),
    .valid(valid4), .probe(probe4), .res_valid(res_valid4), .res_data(res_data4),
    .res_ready(rr4), .level(level4)
`ifdef GB_ISSUER_CNT_EN
    , .issued_cnt(issued_cnt4)
`endif
  );

`ifndef GB_ISSUER_CNT_EN
  assign issued_cnt  = 16'h0000;
  assign issued_cnt4 = 16'h0000;
`endif

  // Stand-in ALU result: operand plus the low seven instruction bits.
  function automatic logic [7:0] alu(input logic [7:0] i, input logic [7:0] d);
    return d + {1'b0, i[6:0]};
  endfunction

  // Processor stand-ins: probe updates at the edge ending the valid cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      probe  <= 8'h00;
      probe4 <= 8'h00;
    end else begin
      if (valid)  probe  <= alu(instruction, data_out);
      if (valid4) probe4 <= alu(instruction4, data_out4);
    end
  end

  // Reference model of the LAT=1 instance: a queue of pending entries and the
  // age of the current operation in cycles since its issue cycle.
  logic [7:0] mq_i[$];
  logic [7:0] mq_d[$];
  bit         m_busy   = 1'b0;
  int         m_age    = 0;
  logic [7:0] m_instr  = 8'h00;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] m_res    = 8'h00;
  int         m_issues = 0;
  int         cnt_offset = 0;
  logic [7:0] got[$];

  always @(posedge clock or negedge reset) begin : model
    int pre;
    bit do_pop;
    bit do_push;
    if (!reset) begin
      mq_i.delete();
      mq_d.delete();
      m_busy   = 1'b0;
      m_age    = 0;
      m_instr  = 8'h00;
      m_data   = 8'h00;
      m_res    = 8'h00;
      m_issues = 0;
    end else begin
      pre     = mq_i.size();
      do_push = push_valid && (pre < DEPTH);
      do_pop  = 1'b0;
      if (!m_busy) begin
        do_pop = (pre > 0);
      end else if (m_age <= LAT1) begin
        if (m_age == 0) m_issues = m_issues + 1;
        if (m_age == LAT1) m_res = alu(m_instr, m_data);
        m_age = m_age + 1;
      end else if (res_ready) begin
        if (pre > 0) do_pop = 1'b1;
        else m_busy = 1'b0;
      end
      if (do_pop) begin
        m_instr = mq_i.pop_front();
        m_data  = mq_d.pop_front();
        m_busy  = 1'b1;
        m_age   = 0;
      end
      if (do_push) begin
        mq_i.push_back(push_instr);
        mq_d.push_back(push_data);
      end
    end
  end

  // Log every result the host accepts from the LAT=1 instance.
  always @(posedge clock) begin
    if (reset && res_valid && res_ready) got.push_back(res_data);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the LAT=1 instance against the model.
  always @(negedge clock) begin
    checkOutput("valid",       {31'b0, valid},       {31'b0, (m_busy && m_age == 0)});
    checkOutput("res_valid",   {31'b0, res_valid},   {31'b0, (m_busy && m_age > LAT1)});
    checkOutput("instruction", {24'b0, instruction}, {24'b0, m_instr});
    checkOutput("data_out",    {24'b0, data_out},    {24'b0, m_data});
    checkOutput("res_data",    {24'b0, res_data},    {24'b0, m_res});
    checkOutput("level",       {28'b0, level},       mq_i.size());
    checkOutput("push_ready",  {31'b0, push_ready},  {31'b0, (mq_i.size() < DEPTH)});
`ifdef GB_ISSUER_CNT_EN
    checkOutput("issued_cnt",  {16'b0, issued_cnt},  {16'b0, 16'(m_issues + cnt_offset)});
`endif
  end

  // Advance to the next cycle and drive the LAT=1 instance inputs.
  task automatic applyStimulus(input logic pv, input logic [7:0] pi, input logic [7:0] pd,
                               input logic rr);
    @(negedge clock);
    push_valid = pv;
    push_instr = pi;
    push_data  = pd;
    res_ready  = rr;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int g0;
    int pulses;
    logic [7:0] held;
    logic [7:0] exp_bp[6];

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst valid",      {31'b0, valid},       32'h0);
    checkOutput("rst push_ready", {31'b0, push_ready},  32'h1);
    checkOutput("rst level",      {28'b0, level},       32'h0);
    checkOutput("rst res_valid4", {31'b0, res_valid4},  32'h0);
    #2 reset = 1'b1;

    $display("[TB] single op");
    applyStimulus(1'b1, 8'h80, 8'h05, 1'b1);
    checkOutput("single c0 valid", {31'b0, valid}, 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("single c1 valid", {31'b0, valid}, 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("single c2 valid", {31'b0, valid}, 32'h1);
    checkOutput("single c2 instr", {24'b0, instruction}, 32'h80);
    checkOutput("single c2 data",  {24'b0, data_out}, 32'h05);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("single c3 valid", {31'b0, valid}, 32'h0);
    checkOutput("single c3 res_valid", {31'b0, res_valid}, 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("single c4 res_valid", {31'b0, res_valid}, 32'h1);
    checkOutput("single c4 res_data",  {24'b0, res_data}, 32'h05);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("single c5 res_valid", {31'b0, res_valid}, 32'h0);

    $display("[TB] fill and overflow");
    applyStimulus(1'b1, 8'h01, 8'h0A, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("fill stalled res_valid", {31'b0, res_valid}, 32'h1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 1'b0);
      if (i == 9) begin
        checkOutput("fill full level",      {28'b0, level},      32'h8);
        checkOutput("fill full push_ready", {31'b0, push_ready}, 32'h0);
      end
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("fill 9th dropped level", {28'b0, level}, 32'h8);
    g0 = got.size();
    repeat (35) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("fill result count", got.size() - g0, 32'd9);
    if (got.size() >= g0 + 9) begin
      checkOutput("fill stalled op result", {24'b0, got[g0]}, 32'h0B);
      checkOutput("fill first result", {24'b0, got[g0+1]}, 32'h32);
      checkOutput("fill last result",  {24'b0, got[g0+8]}, 32'h40);
      for (int k = 2; k <= 7; k++)
        checkOutput("fill order", {24'b0, got[g0+k]}, 32'h30 + 2 * k);
    end

    $display("[TB] back-pressure");
    pulses = 0;
    held   = 8'h00;
    applyStimulus(1'b1, 8'h02, 8'h40, 1'b0);
    pulses += int'(valid);
    applyStimulus(1'b1, 8'h03, 8'h41, 1'b0);
    pulses += int'(valid);
    applyStimulus(1'b1, 8'h04, 8'h42, 1'b0);
    pulses += int'(valid);
    for (int c = 3; c <= 13; c++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      pulses += int'(valid);
      if (c == 4) begin
        held = res_data;
        checkOutput("bp held res_data", {24'b0, res_data}, 32'h42);
      end else if (c > 4) begin
        checkOutput("bp res_data stable", {24'b0, res_data}, {24'b0, held});
        checkOutput("bp res_valid stable", {31'b0, res_valid}, 32'h1);
      end
    end
    checkOutput("bp single pulse", pulses, 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("bp ready cycle valid", {31'b0, valid}, 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("bp second valid", {31'b0, valid}, 32'h1);
    checkOutput("bp second instr", {24'b0, instruction}, 32'h03);
    repeat (20) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);

    $display("[TB] simultaneous push and pop");
    g0 = got.size();
    applyStimulus(1'b1, 8'h05, 8'h50, 1'b0);
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 8'(8'h05 + i), 8'(8'h50 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("pp level before", {28'b0, level}, 32'h4);
    applyStimulus(1'b1, 8'h0A, 8'h55, 1'b1);
    checkOutput("pp level during", {28'b0, level}, 32'h4);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("pp level after", {28'b0, level}, 32'h4);
    checkOutput("pp valid", {31'b0, valid}, 32'h1);
    checkOutput("pp instr", {24'b0, instruction}, 32'h06);
    repeat (25) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    exp_bp = '{8'h55, 8'h57, 8'h59, 8'h5B, 8'h5D, 8'h5F};
    checkOutput("pp result count", got.size() - g0, 32'd6);
    if (got.size() >= g0 + 6) begin
      for (int k = 0; k < 6; k++)
        checkOutput("pp order", {24'b0, got[g0+k]}, {24'b0, exp_bp[k]});
    end

    $display("[TB] reset mid-WAIT");
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    p4v = 1'b1; p4i = 8'h11; p4d = 8'h22;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    p4v = 1'b0;
    repeat (10) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("r4 first result", {24'b0, res_data4}, 32'h33);
    checkOutput("r4 idle res_valid", {31'b0, res_valid4}, 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    p4v = 1'b1; p4i = 8'h12; p4d = 8'h34;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    p4v = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("r4 valid", {31'b0, valid4}, 32'h1);
    checkOutput("r4 instr", {24'b0, instruction4}, 32'h12);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("r4 async valid",      {31'b0, valid4},       32'h0);
    checkOutput("r4 async res_valid",  {31'b0, res_valid4},   32'h0);
    checkOutput("r4 async instr",      {24'b0, instruction4}, 32'h0);
    checkOutput("r4 async data_out",   {24'b0, data_out4},    32'h0);
    checkOutput("r4 async res_data",   {24'b0, res_data4},    32'h0);
    checkOutput("r4 async level",      {28'b0, level4},       32'h0);
    checkOutput("r4 async push_ready", {31'b0, push_ready4},  32'h1);
`ifdef GB_ISSUER_CNT_EN
    checkOutput("r4 async issued_cnt", {16'b0, issued_cnt4},  32'h0);
`endif
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    #2 reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
      checkOutput("r4 discarded res_valid", {31'b0, res_valid4}, 32'h0);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    p4v = 1'b1; p4i = 8'h13; p4d = 8'h01;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    p4v = 1'b0;
    checkOutput("r4 post c1 valid", {31'b0, valid4}, 32'h0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("r4 post c2 valid", {31'b0, valid4}, 32'h1);
    checkOutput("r4 post c2 instr", {24'b0, instruction4}, 32'h13);
    checkOutput("r4 post c2 data",  {24'b0, data_out4}, 32'h01);
    repeat (10) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);

`ifdef GB_ISSUER_CNT_EN
    $display("[TB] issue counter");
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    #2 reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 8'(8'h20 + i), 8'(i), 1'b1);
    repeat (20) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("cnt after five", {16'b0, issued_cnt}, 32'd5);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    #2;
    force dut.issued_cnt_q = 16'hFFFF;
    cnt_offset = 32'h0000FFFF - m_issues;
    #1;
    release dut.issued_cnt_q;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("cnt preload", {16'b0, issued_cnt}, 32'hFFFF);
    applyStimulus(1'b1, 8'h30, 8'h01, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("cnt wrap", {16'b0, issued_cnt}, 32'h0);
`endif

    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
